// File: rtl/f8_accum_if.sv
// Operand/result handshake bundle for f8_accum.
// The master side feeds operands and consumes results; the slave side is the accumulator.
interface f8_accum_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output in_valid, a, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out
  );

  modport slave (
    input  in_valid, a, c_in, out_ready,
    output in_ready, out_valid, sum, c_out
  );
endinterface

// File: rtl/f8_accum.sv
// Frame accumulator: sums COUNT (a + c_in) beats into a WIDTH-bit result with a sticky carry flag.
// Define F8_ACCUM_SATURATE_EN to clamp the frame result to all-ones after the first carry-out.
module f8_accum #(
  parameter int WIDTH = 4,
  parameter int COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  f8_accum_if.slave  bus
);

  // Counter holds beats taken while in ACC, so it only ever needs 0..COUNT-1.
  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic             sticky_q;
  logic             out_valid_q;
  logic             in_ready_q;

  logic             beat_s;
  logic             first_s;
  logic             last_s;
  logic             carry_s;
  logic [WIDTH:0]   add_s;
  logic [WIDTH-1:0] acc_d;
  logic             sticky_d;

  // Next accumulator value and carry bookkeeping for a beat in the current state.
  always_comb begin
    beat_s   = bus.in_valid && in_ready_q;
    first_s  = (state_q == S_IDLE);
    add_s    = (first_s ? {(WIDTH+1){1'b0}} : {1'b0, acc_q})
             + {1'b0, bus.a}
             + {{WIDTH{1'b0}}, bus.c_in};
    carry_s  = add_s[WIDTH];
    sticky_d = carry_s || (!first_s && sticky_q);
`ifdef F8_ACCUM_SATURATE_EN
    if (sticky_d) begin
      acc_d = {WIDTH{1'b1}};
    end else begin
      acc_d = add_s[WIDTH-1:0];
    end
`else
    acc_d = add_s[WIDTH-1:0];
`endif
    if (COUNT == 1) begin
      last_s = 1'b1;
    end else begin
      last_s = !first_s && (cnt_q == CW'(COUNT - 1));
    end
  end

  // Frame FSM with registered handshake outputs; reset wins over any beat or handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CW{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_ACC: begin
          if (beat_s) begin
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            if (last_s) begin
              state_q     <= S_HOLD;
              cnt_q       <= {CW{1'b0}};
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end else begin
              state_q <= S_ACC;
              cnt_q   <= cnt_q + CW'(1);
            end
          end
        end
        S_HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cnt_q       <= {CW{1'b0}};
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Result fields are masked to zero whenever no result is being presented.
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = out_valid_q ? acc_q : {WIDTH{1'b0}};
  assign bus.c_out     = out_valid_q && sticky_q;

endmodule
